ulut_bank: RTL and testbench
============================

ULUT_BANK -- requirements
Module: ulut_bank

Interface
REQ-001 SHALL have parameter NUM_LUT, default 4: number of independent universal-gate channels (1..256).
REQ-002 SHALL have parameter K, default 4: inputs per channel (2..6); function table is 2^K bits.
REQ-003 SHALL have parameter IN_W, default 16: width of shared input pool (2..64); PW = clog2(IN_W) bits per pin selector.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port in_data  input  IN_W  input pool feeding every channel.
REQ-007 SHALL have port cfg_cmd  input  2  configuration command: 0 NOP, 1 SELECT, 2 WRITE, 3 COMMIT.
REQ-008 SHALL have port cfg_data  input  16  command operand.
REQ-009 SHALL have port out  output  NUM_LUT  channel results, bit i = channel i.
REQ-010 SHALL have port cfg_err  output  1  sticky configuration error flag.

Function
REQ-011 Each channel SHALL hold a shadow and an active copy of: func (2^K bits) and pinmap (K fields of PW bits, field j = pool index of input j).
REQ-012 Channel i result SHALL equal active_func[{in_data[pin K-1],...,in_data[pin 0]}]; pin 0 is the index LSB.
REQ-013 Pin selector values >= IN_W SHALL read as 0.
REQ-014 SELECT SHALL latch target channel = cfg_data[7:0], target table = cfg_data[8] (0 func, 1 pinmap), and clear the chunk pointer to 0.
REQ-015 SELECT with cfg_data[7:0] >= NUM_LUT SHALL set cfg_err and mark the selection invalid; a valid SELECT SHALL clear cfg_err.
REQ-016 WRITE SHALL store cfg_data into shadow bits [16*ptr +: 16] of the target table, then increment ptr.
REQ-017 Chunk count SHALL be ceil(2^K/16) for func and ceil(K*PW/16) for pinmap; ptr SHALL wrap to 0 after the last chunk; bits beyond table width SHALL be discarded.
REQ-018 WRITE while selection invalid SHALL change no table and SHALL set cfg_err.
REQ-019 COMMIT SHALL copy all shadow tables of all channels to active in one cycle; active tables SHALL change only on COMMIT.
REQ-020 WRITE SHALL never affect out before a following COMMIT.
REQ-021 Without the REQ-027 macro, out SHALL be combinational from in_data and active tables (zero latency; new tables visible the cycle after COMMIT).
REQ-022 NOP SHALL change no state.

Reset
REQ-023 While rst_n is low at a rising edge, all shadow and active func and pinmap bits SHALL clear to 0, ptr to 0, selection to invalid, cfg_err to 0.
REQ-024 After reset out SHALL be all 0 (zero function tables).
REQ-025 Reset during a partially written table SHALL discard the partial shadow contents; no COMMIT SHALL be implied.
REQ-026 Commands in the reset cycle SHALL be ignored.

Configuration
REQ-027 Macro ULUT_REGOUT_EN defined: out SHALL be registered, one cycle latency from in_data, reset to 0; undefined: out combinational per REQ-021.

Structure
REQ-028 Command encodings (NOP/SELECT/WRITE/COMMIT), chunk width 16 and the table-select bit position SHALL live in shared package ulut_pkg.
REQ-029 One sub-module ulut_cell (pin muxing + function lookup for one channel, parameters K, IN_W) SHALL be instantiated NUM_LUT times.

Verification (defaults NUM_LUT=4, K=4, IN_W=16)
REQ-030 Reset then in_data=0xFFFF -> out=0x0, cfg_err=0.
REQ-031 SELECT 0x000, WRITE 0x8000, SELECT 0x100, WRITE 0x3210, COMMIT, in_data=0x000F -> out[0]=1; in_data=0x0007 -> out[0]=0.
REQ-032 Same sequence without COMMIT, in_data=0x000F -> out=0x0 until COMMIT issued.
REQ-033 SELECT 0x005 -> cfg_err=1; WRITE 0xFFFF -> no table change; SELECT 0x001 -> cfg_err=0.
REQ-034 SELECT 0x002, WRITE 0x6666, WRITE 0x0000 (ptr wrapped, overwrites) then COMMIT -> channel 2 func=0x0000, out[2]=0 for all inputs.
REQ-035 Reset asserted after WRITE before COMMIT, then COMMIT -> out=0x0; with ULUT_REGOUT_EN, out follows in_data one cycle late.

Source files
------------

// File: rtl/ulut_pkg.sv
// Shared definitions for the universal-LUT bank: command encodings, chunk geometry.
package ulut_pkg;

    typedef enum logic [1:0] {
        CMD_NOP    = 2'd0,
        CMD_SELECT = 2'd1,
        CMD_WRITE  = 2'd2,
        CMD_COMMIT = 2'd3
    } cfg_cmd_e;

    localparam int unsigned CHUNK_W  = 16;
    localparam int unsigned CH_W     = 8;
    localparam int unsigned TSEL_BIT = 8;

    // Number of CHUNK_W-bit writes needed to fill a table of the given width.
    function automatic int unsigned num_chunks(input int unsigned bits);
        return (bits + CHUNK_W - 1) / CHUNK_W;
    endfunction

endpackage

// File: rtl/ulut_cell.sv
// One universal-gate channel: K pin selectors into the input pool, then a 2^K-entry lookup.
module ulut_cell #(
    parameter int unsigned K    = 4,
    parameter int unsigned IN_W = 16
) (
    input  logic [IN_W-1:0]           in_data,
    input  logic [2**K-1:0]           func,
    input  logic [K*$clog2(IN_W)-1:0] pinmap,
    output logic                      y
);

    localparam int unsigned PW     = $clog2(IN_W);
    localparam int unsigned POOL_W = 2**PW;

    // Pool padded to a power of two so out-of-range selectors land on zero bits.
    logic [POOL_W-1:0] pool;
    logic [K-1:0]      idx;

    assign pool = POOL_W'(in_data);

    always_comb begin
        idx = '0;
        for (int j = 0; j < K; j++) begin
            idx[j] = pool[pinmap[j*PW +: PW]];
        end
    end

    assign y = func[idx];

endmodule

// File: rtl/ulut_bank.sv
// Bank of NUM_LUT universal gates with shadow/active configuration tables.
// Define ULUT_REGOUT_EN to register out (one cycle latency).
module ulut_bank
    import ulut_pkg::*;
#(
    parameter int unsigned NUM_LUT = 4,
    parameter int unsigned K       = 4,
    parameter int unsigned IN_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_data,
    input  logic [1:0]         cfg_cmd,
    input  logic [15:0]        cfg_data,
    output logic [NUM_LUT-1:0] out,
    output logic               cfg_err
);

    localparam int unsigned FW       = 2**K;
    localparam int unsigned PW       = $clog2(IN_W);
    localparam int unsigned MW       = K*PW;
    localparam int unsigned F_CHUNKS = num_chunks(FW);
    localparam int unsigned M_CHUNKS = num_chunks(MW);
    localparam int unsigned FPAD     = F_CHUNKS*CHUNK_W;
    localparam int unsigned MPAD     = M_CHUNKS*CHUNK_W;
    localparam int unsigned PTR_W    = 2;

    logic [FW-1:0] shadow_func [NUM_LUT];
    logic [FW-1:0] active_func [NUM_LUT];
    logic [MW-1:0] shadow_map  [NUM_LUT];
    logic [MW-1:0] active_map  [NUM_LUT];

    logic [CH_W-1:0]    sel_ch;
    logic               sel_map;
    logic               sel_valid;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   last_ptr;
    logic               sel_in_range;
    logic [NUM_LUT-1:0] out_c;
    cfg_cmd_e           cmd;

    assign cmd          = cfg_cmd_e'(cfg_cmd);
    assign sel_in_range = ({1'b0, cfg_data[CH_W-1:0]} < (CH_W+1)'(NUM_LUT));
    assign last_ptr     = sel_map ? PTR_W'(M_CHUNKS-1) : PTR_W'(F_CHUNKS-1);

    // Overlay one chunk onto a table; bits past the table width fall off.
    function automatic logic [FW-1:0] merge_func(input logic [FW-1:0] cur,
                                                 input logic [PTR_W-1:0] p,
                                                 input logic [15:0] d);
        logic [FPAD-1:0] t;
        t = FPAD'(cur);
        t[p*CHUNK_W +: CHUNK_W] = d;
        return t[FW-1:0];
    endfunction

    function automatic logic [MW-1:0] merge_map(input logic [MW-1:0] cur,
                                                input logic [PTR_W-1:0] p,
                                                input logic [15:0] d);
        logic [MPAD-1:0] t;
        t = MPAD'(cur);
        t[p*CHUNK_W +: CHUNK_W] = d;
        return t[MW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_ch    <= '0;
            sel_map   <= 1'b0;
            sel_valid <= 1'b0;
            ptr       <= '0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < NUM_LUT; i++) begin
                shadow_func[i] <= '0;
                active_func[i] <= '0;
                shadow_map[i]  <= '0;
                active_map[i]  <= '0;
            end
        end else begin
            case (cmd)
                CMD_SELECT: begin
                    sel_ch    <= cfg_data[CH_W-1:0];
                    sel_map   <= cfg_data[TSEL_BIT];
                    sel_valid <= sel_in_range;
                    cfg_err   <= !sel_in_range;
                    ptr       <= '0;
                end
                CMD_WRITE: begin
                    if (sel_valid) begin
                        for (int i = 0; i < NUM_LUT; i++) begin
                            if (sel_ch == CH_W'(i)) begin
                                if (sel_map) begin
                                    shadow_map[i] <= merge_map(shadow_map[i], ptr, cfg_data);
                                end else begin
                                    shadow_func[i] <= merge_func(shadow_func[i], ptr, cfg_data);
                                end
                            end
                        end
                        ptr <= (ptr == last_ptr) ? '0 : ptr + 1'b1;
                    end else begin
                        cfg_err <= 1'b1;
                    end
                end
                CMD_COMMIT: begin
                    for (int i = 0; i < NUM_LUT; i++) begin
                        active_func[i] <= shadow_func[i];
                        active_map[i]  <= shadow_map[i];
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_LUT; g++) begin : g_cell
        ulut_cell #(
            .K    (K),
            .IN_W (IN_W)
        ) u_cell (
            .in_data (in_data),
            .func    (active_func[g]),
            .pinmap  (active_map[g]),
            .y       (out_c[g])
        );
    end

`ifdef ULUT_REGOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_c;
        end
    end
`else
    assign out = out_c;
`endif

endmodule

// File: tb/tb_ulut_bank.sv
// Directed self-checking bench for ulut_bank at default parameters.
module tb_ulut_bank;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic [1:0]  cfg_cmd;
    logic [15:0] cfg_data;
    logic [3:0]  out;
    logic        cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    ulut_bank u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .cfg_cmd  (cfg_cmd),
        .cfg_data (cfg_data),
        .out      (out),
        .cfg_err  (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [15:0] d);
        cfg_cmd  = c;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_cmd  = 2'd0;
        cfg_data = 16'h0;
    endtask

    // Apply a pool value and settle; registered builds need one extra edge.
    task automatic set_in(input logic [15:0] v);
        in_data = v;
`ifdef ULUT_REGOUT_EN
        @(posedge clk);
`endif
        #1;
    endtask

    localparam logic [1:0] NOP = 2'd0, SEL = 2'd1, WR = 2'd2, COM = 2'd3;

    initial begin
        rst_n    = 1'b0;
        in_data  = 16'h0;
        cfg_cmd  = NOP;
        cfg_data = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_in(16'hFFFF);
        check("reset_out", 32'(out), 32'h0);
        check("reset_err", 32'(cfg_err), 32'h0);

        // 4-input AND on channel 0, pins 0..3
        cmd(SEL, 16'h0000);
        cmd(WR,  16'h8000);
        cmd(SEL, 16'h0100);
        cmd(WR,  16'h3210);
        set_in(16'h000F);
        check("no_commit", 32'(out), 32'h0);
        cmd(COM, 16'h0);
        set_in(16'h000F);
        check("and_all_ones", 32'(out), 32'h1);
        set_in(16'h0007);
        check("and_partial", 32'(out), 32'h0);

        // Shadow write stays invisible until the next commit
        cmd(SEL, 16'h0000);
        cmd(WR,  16'h0001);
        set_in(16'h000F);
        check("shadow_hidden", 32'(out), 32'h1);
        cmd(COM, 16'h0);
        set_in(16'h000F);
        check("nor_ones", 32'(out), 32'h0);
        set_in(16'h0000);
        check("nor_zeros", 32'(out), 32'h1);
`ifdef ULUT_REGOUT_EN
        in_data = 16'h000F;
        #1;
        check("regout_lag", 32'(out), 32'h1);
        @(posedge clk);
        #1;
        check("regout_follow", 32'(out), 32'h0);
`endif

        // Channel 1 buffers pool bit 9
        cmd(SEL, 16'h0001);
        cmd(WR,  16'hAAAA);
        cmd(SEL, 16'h0101);
        cmd(WR,  16'h0009);
        cmd(COM, 16'h0);
        set_in(16'h0200);
        check("pin9_high", 32'(out), 32'h3);
        set_in(16'h0000);
        check("pin9_low", 32'(out), 32'h1);

        // Out-of-range selection flags error and blocks writes
        cmd(SEL, 16'h0005);
        check("bad_sel_err", 32'(cfg_err), 32'h1);
        cmd(WR,  16'hFFFF);
        check("bad_wr_err", 32'(cfg_err), 32'h1);
        cmd(COM, 16'h0);
        set_in(16'h0200);
        check("bad_wr_no_change", 32'(out), 32'h3);
        cmd(SEL, 16'h0001);
        check("good_sel_clears", 32'(cfg_err), 32'h0);

        // Channel 2: XOR-ish 0x6666 on pins 0..3
        cmd(SEL, 16'h0102);
        cmd(WR,  16'h3210);
        cmd(SEL, 16'h0002);
        cmd(WR,  16'h6666);
        cmd(COM, 16'h0);
        set_in(16'h0001);
        check("ch2_idx1", 32'(out), 32'h4);
        set_in(16'h0006);
        check("ch2_idx6", 32'(out), 32'h4);

        // Single-chunk table: second write wraps and overwrites
        cmd(SEL, 16'h0002);
        cmd(WR,  16'h6666);
        cmd(WR,  16'h0000);
        cmd(COM, 16'h0);
        set_in(16'h0001);
        check("wrap_idx1", 32'(out), 32'h0);
        set_in(16'h0006);
        check("wrap_idx6", 32'(out), 32'h0);
        set_in(16'h0000);
        check("wrap_idx0", 32'(out), 32'h1);

        // Reset mid-configuration discards shadow; commands in reset ignored
        cmd(SEL, 16'h0000);
        cmd(WR,  16'hFFFF);
        rst_n    = 1'b0;
        cfg_cmd  = SEL;
        cfg_data = 16'h0005;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cfg_cmd  = NOP;
        cfg_data = 16'h0;
        check("reset_cmd_ignored", 32'(cfg_err), 32'h0);
        cmd(COM, 16'h0);
        set_in(16'h0000);
        check("post_reset_zeros", 32'(out), 32'h0);
        set_in(16'h000F);
        check("post_reset_ones", 32'(out), 32'h0);
        cmd(WR,  16'h1234);
        check("post_reset_sel_invalid", 32'(cfg_err), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
